alarm_arm_ctrl: RTL
===================

Name: alarm_arm_ctrl

Overview:
Arming/trip controller for the security system. It takes operator arm requests, validated keypad codes and door/window sensor inputs. It runs the exit-delay, armed, entry-delay and alarm sequence, and drives sys_active, which feeds the beep/blink stage's sysActive input. It sits directly upstream of the LED/speaker driver and directly downstream of the keypad code checker.

Parameters:
N_SENSORS, 4, number of sensor zones
EXIT_CYCLES, 500000000, exit-delay dwell in clk cycles (10 s at 50 MHz)
ENTRY_CYCLES, 500000000, entry-delay dwell in clk cycles
ALARM_CYCLES, 32'hFFFFFFFF, alarm dwell before automatic re-arm (about 86 s at 50 MHz)
CNT_W, 32, timer width; must hold max(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous, active-low reset
arm_req  in  1  one-cycle arm request pulse
code_ok  in  1  one-cycle pulse: keypad code validated
sensor  in  N_SENSORS  raw asynchronous zone inputs; 1 = open/tripped
sys_active  out  1  registered; 1 only in ALARM; drives beep/blink sysActive
armed  out  1  1 in ARMED, ENTRY_DELAY and ALARM
delay_active  out  1  1 in EXIT_DELAY or ENTRY_DELAY
state  out  3  current state encoding
trip_zone  out  N_SENSORS  zones latched at the moment of trip
arm_fault  out  1  one-cycle pulse: arm rejected because a zone was open

Behaviour:
- Reset: rst_n sampled low at a clk edge gives state=DISARMED, timer=0, sync flops=0, trip_zone=0. All outputs are 0 the following cycle. Reset mid-sequence, including during ALARM, aborts immediately with no residual pulse.
- Sensors pass through a 2-flop synchronizer (sensor_s). FSM decisions use sensor_s only, so latency from sensor to decision is 2 cycles.
- States (encodings): DISARMED 0, EXIT_DELAY 1, ARMED 2, ENTRY_DELAY 3, ALARM 4.
- The timer clears to 0 on every state change and increments by 1 each cycle while in a timed state.
- Timeout fires when timer == X-1, so the state holds for exactly X cycles.
- DISARMED:
  - arm_req with sensor_s==0 → EXIT_DELAY.
  - arm_req with sensor_s!=0 → stay; arm_fault=1 for the next cycle.
  - code_ok is ignored.
- EXIT_DELAY:
  - code_ok → DISARMED.
  - Timeout → ARMED.
  - Sensors are ignored.
- ARMED:
  - code_ok → DISARMED.
  - Else sensor_s!=0 → ENTRY_DELAY, with trip_zone <= sensor_s.
  - arm_req is ignored.
- ENTRY_DELAY:
  - code_ok → DISARMED.
  - Timeout → ALARM.
  - Additional zones tripping here are OR-ed into trip_zone.
- ALARM:
  - code_ok → DISARMED.
  - Timeout → ARMED. If a zone is still open, the next cycle re-trips to ENTRY_DELAY.
- Priority: code_ok beats timeout and sensor trip in the same cycle. In DISARMED, arm_req is processed and a coincident code_ok has no effect.
- trip_zone clears on entry to DISARMED or EXIT_DELAY and holds otherwise.
- All outputs are registered and decoded from the next state, so they align with state.
- The timer never wraps, because it clears on timeout.
- Arming from DISARMED to sys_active requires EXIT_CYCLES plus ENTRY_CYCLES after the trip, plus sync latency.

Optional Feature:
- Macro: ALARM_PANIC_EN.
- When defined:
  - Adds input port panic (1 bit, 2-flop synchronized).
  - A synchronized panic=1 in any state other than ALARM → ALARM next cycle, with trip_zone unchanged.
  - Panic outranks timeout and sensor events but not code_ok. code_ok and panic together → DISARMED.
- When undefined: no panic port and no related logic.

Decomposition:
- Package alarm_pkg holds the state localparams/enum (ST_DISARMED..ST_ALARM, 3-bit) and the default cycle constants for the 50 MHz clock.
- Sub-module sensor_sync: parameterised-width 2-flop synchronizer with synchronous active-low reset. It is instantiated for sensor and, under ALARM_PANIC_EN, for panic.

Test Plan (N_SENSORS=4, EXIT_CYCLES=8, ENTRY_CYCLES=6, ALARM_CYCLES=20):
- Arm with sensor=0 → state=1 the cycle after the arm_req pulse; exactly 8 cycles later state=2, armed=1, delay_active=0.
- ARMED, sensor=4'b0010 → state=3 three cycles later with trip_zone=0010. With no code, ALARM occurs 6 cycles later: sys_active=1 for 20 cycles, then state=2.
- Arm with sensor=4'b1000 held → arm_fault high exactly 1 cycle, state stays 0.
- ENTRY_DELAY, with code_ok coincident with the timeout cycle → state=0, sys_active never 1, trip_zone=0.
- ALARM, rst_n low for 1 cycle → next cycle all outputs 0 and state=0; subsequent arm works normally.
- ALARM_PANIC_EN: panic=1 while DISARMED → state=4 and sys_active=1 after sync latency; a following code_ok → state=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encodings and default 50 MHz dwell constants for the arming controller.
package alarm_pkg;
  localparam logic [2:0] ST_DISARMED   = 3'd0;
  localparam logic [2:0] ST_EXIT_DELAY = 3'd1;
  localparam logic [2:0] ST_ARMED      = 3'd2;
  localparam logic [2:0] ST_ENTRY_DELAY= 3'd3;
  localparam logic [2:0] ST_ALARM      = 3'd4;

  localparam longint unsigned DEF_EXIT_CYCLES  = 64'd500_000_000;
  localparam longint unsigned DEF_ENTRY_CYCLES = 64'd500_000_000;
  localparam longint unsigned DEF_ALARM_CYCLES = 64'hFFFF_FFFF;
endpackage

// File: rtl/sensor_sync.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous active-low reset.
module sensor_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/alarm_arm_ctrl.sv
// Arming/trip FSM: exit delay, armed, entry delay, alarm with auto re-arm.
// Optional panic input enabled with macro ALARM_PANIC_EN.
module alarm_arm_ctrl
  import alarm_pkg::*;
#(
  parameter int              N_SENSORS    = 4,
  parameter int              CNT_W        = 32,
  parameter longint unsigned EXIT_CYCLES  = DEF_EXIT_CYCLES,
  parameter longint unsigned ENTRY_CYCLES = DEF_ENTRY_CYCLES,
  parameter longint unsigned ALARM_CYCLES = DEF_ALARM_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm_req,
  input  logic                 code_ok,
  input  logic [N_SENSORS-1:0] sensor,
`ifdef ALARM_PANIC_EN
  input  logic                 panic,
`endif
  output logic                 sys_active,
  output logic                 armed,
  output logic                 delay_active,
  output logic [2:0]           state,
  output logic [N_SENSORS-1:0] trip_zone,
  output logic                 arm_fault
);
  localparam logic [CNT_W-1:0] EXIT_LIM  = CNT_W'(EXIT_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0] ENTRY_LIM = CNT_W'(ENTRY_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0] ALARM_LIM = CNT_W'(ALARM_CYCLES - 64'd1);

  logic [N_SENSORS-1:0] sensor_s;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [N_SENSORS-1:0] trip_q, trip_d;
  logic                 fault_q, fault_d;
  logic                 sys_active_q, armed_q, delay_q;
  logic                 tmo;

  sensor_sync #(.W(N_SENSORS)) u_sensor_sync (
    .clk(clk), .rst_n(rst_n), .d(sensor), .q(sensor_s)
  );

`ifdef ALARM_PANIC_EN
  logic panic_s;
  sensor_sync #(.W(1)) u_panic_sync (
    .clk(clk), .rst_n(rst_n), .d(panic), .q(panic_s)
  );
`endif

  always_comb begin
    tmo = 1'b0;
    case (state_q)
      ST_EXIT_DELAY:  tmo = (timer_q == EXIT_LIM);
      ST_ENTRY_DELAY: tmo = (timer_q == ENTRY_LIM);
      ST_ALARM:       tmo = (timer_q == ALARM_LIM);
      default:        tmo = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    trip_d  = trip_q;
    fault_d = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (arm_req) begin
          if (sensor_s == '0) state_d = ST_EXIT_DELAY;
          else                fault_d = 1'b1;
        end
      end
      ST_EXIT_DELAY: begin
        if (code_ok)  state_d = ST_DISARMED;
        else if (tmo) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (code_ok) state_d = ST_DISARMED;
        else if (sensor_s != '0) begin
          state_d = ST_ENTRY_DELAY;
          trip_d  = sensor_s;
        end
      end
      ST_ENTRY_DELAY: begin
        if (code_ok) state_d = ST_DISARMED;
        else begin
          trip_d = trip_q | sensor_s;
          if (tmo) state_d = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (code_ok)  state_d = ST_DISARMED;
        else if (tmo) state_d = ST_ARMED;
      end
      default: state_d = ST_DISARMED;
    endcase
`ifdef ALARM_PANIC_EN
    // Panic loses only to code_ok; zones latched so far are preserved.
    if (panic_s && !code_ok && state_q != ST_ALARM) begin
      state_d = ST_ALARM;
      trip_d  = trip_q;
      fault_d = 1'b0;
    end
`endif
    if (state_d == ST_DISARMED || state_d == ST_EXIT_DELAY) trip_d = '0;

    if (state_d != state_q) timer_d = '0;
    else if (state_q == ST_EXIT_DELAY || state_q == ST_ENTRY_DELAY || state_q == ST_ALARM)
      timer_d = timer_q + 1'b1;
    else timer_d = '0;
  end

  // Outputs are decoded from next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_DISARMED;
      timer_q      <= '0;
      trip_q       <= '0;
      fault_q      <= 1'b0;
      sys_active_q <= 1'b0;
      armed_q      <= 1'b0;
      delay_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      trip_q       <= trip_d;
      fault_q      <= fault_d;
      sys_active_q <= (state_d == ST_ALARM);
      armed_q      <= (state_d == ST_ARMED) || (state_d == ST_ENTRY_DELAY) || (state_d == ST_ALARM);
      delay_q      <= (state_d == ST_EXIT_DELAY) || (state_d == ST_ENTRY_DELAY);
    end
  end

  assign state        = state_q;
  assign trip_zone    = trip_q;
  assign arm_fault    = fault_q;
  assign sys_active   = sys_active_q;
  assign armed        = armed_q;
  assign delay_active = delay_q;
endmodule
